// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: byte-stream command sequencer that initiates ALU operations.
// It accepts a command byte, then an A byte and a B byte, over a valid/ready
// input stream. It drives the registered ALU operands and control, captures
// the result and carry after one EXEC cycle, and returns them over a
// valid/ready output stream.
//
// Optional feature (macro ALU_SEQ_CHAIN_EN): an accumulator holds the last
// result. A command with bit [7] set loads alu_a from the accumulator and
// skips the A byte.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_ready       command/operand byte stream
//   out_data/out_carry/out_valid/   result stream
//   out_ready
//   alu_a/alu_b/alu_ctrl/alu_cnt    registered ALU operand/control drive
//   alu_res/alu_cout                combinational ALU result and carry-out
//   busy                            transaction in progress (state != IDLE)
module alu_seq_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    output logic [2:0]        alu_cnt,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    output logic              busy
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 3;

    // Command byte layout
    typedef struct packed {
        logic             chain;
        logic             rsvd;
        logic [CNT_W-1:0] cnt;
        logic [OP_W-1:0]  op;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_d, busy_d;
    logic [DATA_W-1:0] out_data_d;
    logic              out_carry_d, out_valid_d;
    logic [DATA_W-1:0] alu_a_d, alu_b_d;
    logic [OP_W-1:0]   alu_ctrl_d;
    logic [CNT_W-1:0]  alu_cnt_d;
    cmd_t              cmd;
    logic              in_fire;
    logic              unused_cmd_bits;

`ifdef ALU_SEQ_CHAIN_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    assign cmd     = cmd_t'(in_data[7:0]);
    assign in_fire = in_valid && in_ready;
    // Reserved bit is ignored; chain bit is ignored when chaining is not built
    assign unused_cmd_bits = cmd.rsvd ^ cmd.chain;

    // Next-state and next-register computation
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data;
        out_carry_d = out_carry;
        out_valid_d = out_valid;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_ctrl_d  = alu_ctrl;
        alu_cnt_d   = alu_cnt;
`ifdef ALU_SEQ_CHAIN_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    alu_ctrl_d = cmd.op;
                    alu_cnt_d  = cmd.cnt;
`ifdef ALU_SEQ_CHAIN_EN
                    if (cmd.chain) begin
                        alu_a_d = acc_q;
                        state_d = GET_B;
                    end else begin
                        state_d = GET_A;
                    end
`else
                    state_d = GET_A;
`endif
                end
            end
            GET_A: begin
                if (in_fire) begin
                    alu_a_d = in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (in_fire) begin
                    alu_b_d = in_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_data_d  = alu_res;
                out_carry_d = alu_cout;
                out_valid_d = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
                acc_d       = alu_res;
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered decodes of the upcoming state
        in_ready_d = (state_d == IDLE) || (state_d == GET_A) || (state_d == GET_B);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            alu_cnt   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_data  <= out_data_d;
            out_carry <= out_carry_d;
            out_valid <= out_valid_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_ctrl  <= alu_ctrl_d;
            alu_cnt   <= alu_cnt_d;
`ifdef ALU_SEQ_CHAIN_EN
            acc_q     <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a behavioural 8-bit ALU attached.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_ctrl, alu_cnt;
    logic [7:0] alu_res;
    logic       alu_cout;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_carry(out_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_cnt  (alu_cnt),
        .alu_res  (alu_res),
        .alu_cout (alu_cout),
        .busy     (busy)
    );

    // ALU model: 0 add, 1 sub (carry = no borrow), 2 and, 3 or, 4 xor,
    // 5 shl by cnt, 6 shr by cnt, 7 pass A
    always_comb begin
        logic [8:0] sum;
        sum      = 9'd0;
        alu_res  = 8'h00;
        alu_cout = 1'b0;
        case (alu_ctrl)
            3'd0: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_res = sum[7:0]; alu_cout = sum[8]; end
            3'd1: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1; alu_res = sum[7:0]; alu_cout = sum[8]; end
            3'd2: alu_res = alu_a & alu_b;
            3'd3: alu_res = alu_a | alu_b;
            3'd4: alu_res = alu_a ^ alu_b;
            3'd5: alu_res = alu_a << alu_cnt;
            3'd6: alu_res = alu_a >> alu_cnt;
            default: alu_res = alu_a;
        endcase
    end

    // Count bytes that will transfer on the next rising edge
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        bit ok = 0;
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    // Called just after the B-accept edge: checks EXEC timing, result, and handshake
    task automatic get_resp(input logic [7:0] exp_d, input logic exp_c, input string tag);
        @(negedge clk);
        check({tag, "_exec_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_exec_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input logic exp_c, input int gap,
                           input string tag);
        send_byte(cmd, gap, {tag, "_cmd"});
        send_byte(a, gap, {tag, "_a"});
        send_byte(b, gap, {tag, "_b"});
        get_resp(exp_d, exp_c, tag);
    endtask

    initial begin
        int hs0;
        logic [7:0] held;

        // Reset state
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(in_ready), 32'd1);

        // Add with carry
        run_txn(8'h00, 8'hF0, 8'h20, 8'h10, 1'b1, 0, "add_carry");
        check("add_ctrl", 32'(alu_ctrl), 32'd0);

        // Subtract both directions (bit 6 reserved must be ignored)
        run_txn(8'h01, 8'h05, 8'h03, 8'h02, 1'b1, 0, "sub_pos");
        run_txn(8'h41, 8'h03, 8'h05, 8'hFE, 1'b0, 0, "sub_neg");
        check("sub_ctrl", 32'(alu_ctrl), 32'd1);

        // Shift-left by 3: cmd = cnt 3, op 5
        run_txn(8'h1D, 8'h11, 8'h00, 8'h88, 1'b0, 0, "shl3");
        check("shl_cnt", 32'(alu_cnt), 32'd3);
        check("keep_alu_a", 32'(alu_a), 32'h11);

        // Backpressure: hold out_ready low in RESP with a new command waiting
        send_byte(8'h00, 0, "bp_cmd");
        send_byte(8'h40, 0, "bp_a");
        send_byte(8'h01, 0, "bp_b");
        @(posedge clk); #1;
        held = out_data;
        check("bp_first", 32'(held), 32'h41);
        in_valid = 1'b1;
        in_data  = 8'h04;
        hs0 = hs_cnt;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(held));
            check("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp_no_accept", 32'(hs_cnt - hs0), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_rel_busy", 32'(busy), 32'd0);
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_cmd_taken", 32'(hs_cnt - hs0), 32'd1);
        check("bp_ctrl", 32'(alu_ctrl), 32'd4);
        send_byte(8'h0F, 0, "bp2_a");
        send_byte(8'hFF, 0, "bp2_b");
        get_resp(8'hF0, 1'b0, "bp_xor");

        // Reset mid-transaction after the A byte
        send_byte(8'h03, 0, "rm_cmd");
        send_byte(8'h77, 0, "rm_a");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rm_alu_a", 32'(alu_a), 32'd0);
        check("rm_alu_b", 32'(alu_b), 32'd0);
        check("rm_ctrl", 32'(alu_ctrl), 32'd0);
        check("rm_cnt", 32'(alu_cnt), 32'd0);
        check("rm_out_data", 32'(out_data), 32'd0);
        check("rm_out_carry", 32'(out_carry), 32'd0);
        check("rm_valid", 32'(out_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rm_ready", 32'(in_ready), 32'd1);
        run_txn(8'h00, 8'h01, 8'h01, 8'h02, 1'b0, 0, "rm_fresh");

        // Chaining
`ifdef ALU_SEQ_CHAIN_EN
        run_txn(8'h00, 8'h10, 8'h05, 8'h15, 1'b0, 0, "ch_seed");
        hs0 = hs_cnt;
        send_byte(8'h80, 0, "ch_cmd");
        send_byte(8'h01, 0, "ch_b");
        check("ch_hs", 32'(hs_cnt - hs0), 32'd2);
        check("ch_alu_a", 32'(alu_a), 32'h15);
        get_resp(8'h16, 1'b0, "ch_res");
`else
        hs0 = hs_cnt;
        send_byte(8'h80, 0, "nc_cmd");
        send_byte(8'h10, 0, "nc_a");
        @(negedge clk);
        check("nc_wait_b", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_byte(8'h05, 0, "nc_b");
        check("nc_hs", 32'(hs_cnt - hs0), 32'd3);
        get_resp(8'h15, 1'b0, "nc_res");
`endif

        // Gapped input with random idle cycles
        for (int i = 0; i < 3; i++) begin
            hs0 = hs_cnt;
            run_txn(8'h00, 8'h33, 8'h44, 8'h77, 1'b0, int'($urandom_range(1, 4)), "gap_add");
            check("gap_hs", 32'(hs_cnt - hs0), 32'd3);
        end
        hs0 = hs_cnt;
        run_txn(8'h01, 8'h00, 8'h01, 8'hFF, 1'b0, int'($urandom_range(1, 4)), "gap_sub");
        check("gap_sub_hs", 32'(hs_cnt - hs0), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
